uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter FRAME_WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are 2 or more.
REQ-003 Parameter CNT_WIDTH, default $clog2(CLKS_PER_BIT), baud counter width.
REQ-004 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 tx_data  input  FRAME_WIDTH  parallel byte to transmit; sampled only on accept.
REQ-007 tx_valid  input  1  requester has data on tx_data.
REQ-008 tx_ready  output  1  controller can accept; high only in IDLE.
REQ-009 tx_load  output  1  one-cycle pulse on accept; the load strobe for the frame shift register.
REQ-010 tx_ser  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  high in START, DATA and STOP.
REQ-012 tx_done  output  1  one-cycle pulse when the stop bit completes.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP, with a registered, glitch-free tx_ser.
REQ-014 Accept occurs when tx_valid and tx_ready are both high on a clk edge: capture tx_data, pulse tx_load, then go to START.
REQ-015 tx_ser SHALL drop to 0 in the cycle after accept (latency 1) and hold for CLKS_PER_BIT cycles (START).
REQ-016 DATA SHALL emit FRAME_WIDTH bits LSB first, each held for exactly CLKS_PER_BIT cycles; a bit index of width $clog2(FRAME_WIDTH) counts 0..FRAME_WIDTH-1.
REQ-017 STOP SHALL drive tx_ser=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 tx_done SHALL pulse high for exactly the first IDLE cycle after STOP, and tx_ready SHALL be high in that same cycle.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and hold at 0 in IDLE.
REQ-020 tx_valid and tx_data changes while busy SHALL be ignored; the captured frame is not altered mid-transmission.
REQ-021 Back-to-back transfers (tx_valid held high): accept-to-accept spacing is (FRAME_WIDTH+2)*CLKS_PER_BIT+1 cycles.
REQ-022 tx_ready SHALL not depend combinationally on tx_valid.
REQ-023 No state other than IDLE SHALL be entered without an accept; illegal encodings SHALL recover to IDLE.

Reset
REQ-024 While rst=0, asynchronously: state=IDLE, tx_ser=1, tx_ready=1, tx_busy=0, tx_load=0, tx_done=0, counters=0, data register=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with tx_ser=1 and no tx_done pulse.
REQ-026 The first accept is possible on the first clk edge after rst deasserts.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP) and the default FRAME_WIDTH and CLKS_PER_BIT constants.
REQ-028 The baud counter SHALL be a sub-module uart_baud_cnt (inputs clk, rst, en; output bit_end).
REQ-029 The FSM, bit index and frame shift register SHALL live in uart_tx_ctrl.

Verification (CLKS_PER_BIT=4, FRAME_WIDTH=8)
REQ-030 Reset mid-frame: release reset, then tx_ready=1, tx_ser=1 and all pulses 0; assert rst at cycle 10 of a frame -> tx_ser=1 at once and no tx_done.
REQ-031 Single byte: accept tx_data=0xA5 -> tx_ser holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total), then tx_done pulses in cycle 41.
REQ-032 Data hold: hold tx_valid=1 and change tx_data to 0xFF during the frame -> 0xA5 frame unchanged; the next accept occurs exactly 41 cycles after the first.
REQ-033 Boundaries: send 0x00 and then 0xFF -> data bits all 0 and then all 1; start and stop bits correct; tx_busy high for exactly 40 cycles each.
REQ-034 Handshake: when tx_valid rises while busy -> tx_ready=0, and no tx_load until IDLE; tx_load is high for exactly one cycle per accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEF_FRAME_WIDTH  = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: runs 0..CLKS_PER_BIT-1 while enabled, flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_end
);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;

  assign bit_end = en && (cnt_reg == CNT_WIDTH'(CLKS_PER_BIT - 1));

  // Wraps to 0 on every bit boundary and parks at 0 whenever disabled.
  always_comb begin
    cnt_next = '0;
    if (en && !bit_end) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte intake, 8N1-style framing, LSB first.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx_load,
  output logic                   tx_ser,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int IDX_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

  tx_state_t              state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [FRAME_WIDTH-1:0] shift_reg, shift_next;
  logic [FRAME_WIDTH-1:0] shift_dn;
  logic                   ser_reg, ser_next;
  logic                   done_reg, done_next;
  logic                   accept;
  logic                   bit_end;

  assign tx_ready = (state_reg == IDLE);
  // Gated by rst so no load strobe escapes while the block is held in reset.
  assign accept   = tx_valid && tx_ready && rst;
  assign tx_load  = accept;
  assign tx_busy  = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
  assign tx_ser   = ser_reg;
  assign tx_done  = done_reg;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (tx_busy),
    .bit_end (bit_end)
  );

  // One-place right shift of the frame register, zero fill at the MSB.
  for (genvar gi = 0; gi < FRAME_WIDTH; gi++) begin : g_shift
    if (gi == FRAME_WIDTH - 1) begin : g_msb
      assign shift_dn[gi] = 1'b0;
    end else begin : g_mid
      assign shift_dn[gi] = shift_reg[gi+1];
    end
  end

  // tx_ser is computed one cycle ahead so the line comes straight from a flop.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    ser_next   = ser_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        ser_next = 1'b1;
        if (accept) begin
          shift_next = tx_data;
          idx_next   = '0;
          ser_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          ser_next   = shift_reg[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_reg == IDX_W'(FRAME_WIDTH - 1)) begin
            idx_next   = '0;
            ser_next   = 1'b1;
            state_next = STOP;
          end else begin
            idx_next   = idx_reg + 1'b1;
            shift_next = shift_dn;
            ser_next   = shift_dn[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        ser_next   = 1'b1;
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      shift_reg <= '0;
      ser_reg   <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      ser_reg   <= ser_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl at CLKS_PER_BIT=4, FRAME_WIDTH=8.
module tb_uart_tx_ctrl;

  localparam int FW   = 8;
  localparam int CPB  = 4;
  localparam int NBIT = FW + 2;
  localparam int NCYC = NBIT * CPB;

  logic          clk;
  logic          rst;
  logic [FW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_load;
  logic          tx_ser;
  logic          tx_busy;
  logic          tx_done;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int frame_no = 0;

  // Expected line pattern per frame, bit 0 = start bit, bit 9 = stop bit.
  logic [NBIT-1:0] exp_q[$];

  uart_tx_ctrl #(
    .FRAME_WIDTH  (FW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_load  (tx_load),
    .tx_ser   (tx_ser),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: captures the 40 line samples following each load strobe and
  // checks them against the next queued pattern on the first idle cycle.
  initial begin : monitor
    logic [NCYC-1:0] samples;
    logic [NCYC-1:0] exp_line;
    logic [NBIT-1:0] pat;
    int nsamp;
    int busy_cnt;
    logic stray;
    logic capturing;
    capturing = 1'b0;
    nsamp = 0;
    busy_cnt = 0;
    stray = 1'b0;
    samples = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        capturing = 1'b0;
      end else begin
        if (capturing) begin
          if (nsamp < NCYC) begin
            samples[nsamp] = tx_ser;
            if (tx_busy) busy_cnt++;
            if (tx_done || tx_load || tx_ready) stray = 1'b1;
            nsamp++;
          end else begin
            capturing = 1'b0;
            frame_no++;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 64'(samples), 64'(0));
            end else begin
              pat = exp_q.pop_front();
              for (int k = 0; k < NCYC; k++) exp_line[k] = pat[k / CPB];
              check("serial_line", 64'(samples), 64'(exp_line));
              check("busy_cycles", 64'(busy_cnt), 64'(NCYC));
              check("done_ready_after_stop", 64'({tx_done, tx_ready}), 64'(2'b11));
              check("no_load_done_ready_midframe", 64'(stray), 64'(0));
              $display("frame %0d: line=%h expected=%h busy=%0d", frame_no, samples, exp_line, busy_cnt);
            end
          end
        end
        if (tx_load && !capturing) begin
          capturing = 1'b1;
          nsamp = 0;
          busy_cnt = 0;
          stray = 1'b0;
        end
      end
    end
  end

  task automatic wait_load();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_load) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("load_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic send(input logic [FW-1:0] d, input logic [NBIT-1:0] pat);
    exp_q.push_back(pat);
    @(posedge clk);
    #1;
    tx_data  = d;
    tx_valid = 1'b1;
    wait_load();
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'h3C;
    wait_done();
  endtask

  initial begin : stimulus
    int gap;
    bit seen;
    bit spurious;
    rst      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Reset values, with and without a pending request.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({tx_ser, tx_ready, tx_busy, tx_load, tx_done}), 64'(5'b11000));
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    exp_q.push_back(10'b1101001010);
    #1;
    check("reset_no_load", 64'(tx_load), 64'(0));

    // First accept on the first edge after release; single 0xA5 frame.
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("load_after_release", 64'(tx_load), 64'(1));
    @(posedge clk);
    #1;
    check("start_after_first_edge", 64'({tx_busy, tx_ser}), 64'(2'b10));
    tx_valid = 1'b0;
    wait_done();

    // Valid held: 0xA5 captured, data switched to 0xFF while busy.
    exp_q.push_back(10'b1101001010);
    exp_q.push_back(10'b1111111110);
    @(posedge clk);
    #1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    wait_load();
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    gap  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gap == 20) check("ready_low_while_busy", 64'(tx_ready), 64'(0));
      if (tx_load) begin
        seen = 1'b1;
        break;
      end
      gap++;
    end
    check("b2b_load_seen", 64'(seen), 64'(1));
    check("accept_spacing", 64'(gap), 64'(41));
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_done();

    // Boundary patterns.
    send(8'h00, 10'b1000000000);
    send(8'hFF, 10'b1111111110);

    // Reset asserted in cycle 10 of a frame aborts it without tx_done.
    @(posedge clk);
    #1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    wait_load();
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("ser_low_before_abort", 64'(tx_ser), 64'(0));
    #1;
    rst = 1'b0;
    #1;
    check("abort_outputs", 64'({tx_ser, tx_ready, tx_busy, tx_load, tx_done}), 64'(5'b11000));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_done || tx_busy) spurious = 1'b1;
    end
    check("no_done_after_abort", 64'(spurious), 64'(0));

    // Recovery frame after the aborted one.
    send(8'hA5, 10'b1101001010);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
